// File: rtl/mips_mon_pkg.sv
// Shared definitions for the MIPS run monitor: FSM states, halt reasons,
// and the width of one store-trace entry ({address, data}).
package mips_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] HR_NONE = 2'b00;
  localparam logic [1:0] HR_WDOG = 2'b01;
  localparam logic [1:0] HR_LOOP = 2'b10;

  localparam int TRACE_W = 64;

endpackage

// File: rtl/mips_trace_fifo.sv
// First-word-fall-through store-trace FIFO. The head entry is always visible
// on 'head' while the FIFO is not empty. When the FIFO is full, a push is
// accepted only together with a pop. Full and empty are told apart by one
// extra pointer bit.
module mips_trace_fifo
  import mips_mon_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [TRACE_W-1:0] push_data,
  input  logic               pop,
  output logic [TRACE_W-1:0] head,
  output logic               empty,
  output logic               full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [TRACE_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer advance; wrap-around comes for free from the pointer width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; the contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mips_run_monitor.sv
// Run control and observation for the MIPS core. The block starts the core,
// counts RUN cycles, and halts the core on a watchdog limit or on a PC
// self-loop. Every data-memory store made in RUN goes into a trace FIFO.
module mips_run_monitor
  import mips_mon_pkg::*;
#(
  parameter int unsigned MAX_CYCLES  = 101,
  parameter int unsigned STALL_LIMIT = 4,
  parameter int unsigned TRACE_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] cpu_pc,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        cpu_run_en,
  output logic        halted,
  output logic [1:0]  halt_reason,
  output logic [31:0] cycle_count,
  output logic        trace_valid,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  input  logic        trace_rd,
  output logic        trace_overflow
);

  // A halt fires in the cycle whose increment reaches the limit.
  localparam logic [31:0] WDOG_LAST = 32'(MAX_CYCLES - 1);
  localparam logic [31:0] LOOP_LAST = 32'(STALL_LIMIT - 2);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t               state;
  logic [31:0]          stall_cnt;
  logic [31:0]          prev_pc;
  logic                 first_cyc;
  logic                 pc_same;
  logic                 loop_hit;
  logic                 wdog_hit;
  logic                 store_push;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [TRACE_W-1:0]   fifo_head;

  // The first RUN cycle only loads prev_pc, so it never counts as a repeat.
  assign pc_same    = !first_cyc && (cpu_pc == prev_pc);
  assign loop_hit   = pc_same && (stall_cnt == LOOP_LAST);
  assign wdog_hit   = (cycle_count == WDOG_LAST);
  assign store_push = (state == ST_RUN) && mem_we;

  // Run-control FSM with registered core enable, halt flag and reason.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cpu_run_en  <= 1'b0;
      halted      <= 1'b0;
      halt_reason <= HR_NONE;
      cycle_count <= '0;
      stall_cnt   <= '0;
      prev_pc     <= '0;
      first_cyc   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state       <= ST_RUN;
            cpu_run_en  <= 1'b1;
            halted      <= 1'b0;
            halt_reason <= HR_NONE;
            cycle_count <= '0;
            stall_cnt   <= '0;
            first_cyc   <= 1'b1;
          end
        end
        ST_RUN: begin
          cycle_count <= sat_inc(cycle_count);
          prev_pc     <= cpu_pc;
          first_cyc   <= 1'b0;
          stall_cnt   <= pc_same ? stall_cnt + 32'd1 : '0;
          if (loop_hit || wdog_hit) begin
            state       <= ST_HALTED;
            cpu_run_en  <= 1'b0;
            halted      <= 1'b1;
            halt_reason <= loop_hit ? HR_LOOP : HR_WDOG;
          end
        end
        default: begin
          state      <= ST_IDLE;
          cpu_run_en <= 1'b0;
          halted     <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: a store arrived while the FIFO was full and nothing was popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_overflow <= 1'b0;
    end else if (store_push && fifo_full && !trace_rd) begin
      trace_overflow <= 1'b1;
    end
  end

  mips_trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (store_push),
    .push_data ({mem_addr, mem_wdata}),
    .pop       (trace_rd),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign trace_valid = !fifo_empty;
  assign trace_addr  = fifo_head[63:32];
  assign trace_data  = fifo_head[31:0];

endmodule
